mmu_feeder: RTL and testbench

Sequencing stage directly upstream of the systolic MMU top level. On a start pulse, it snapshots a 2x2 activation tile and a 2x2 weight tile, then runs three phases. First, a one-cycle weight load. Second, a diagonally skewed activation stream on the two row inputs with `valid` asserted. Third, a zero-filled drain window so the accumulators and unified buffer see the final partial sums. All outputs are registered and drive the MMU top-level `load_weight`, `valid`, `a_in1`/`a_in2` and `weight1`..`weight4` inputs directly.

---
 rtl/mmu_feeder.sv | 202 ++++++++++++++++++++
 tb/tb_mmu_feeder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mmu_feeder.sv
// Sequencer feeding the 2x2 systolic MMU: weight load, skewed activation feed, zero drain.
// Optional done interrupt latch enabled by defining MMU_FEEDER_DONE_IRQ_EN.
module mmu_feeder #(
  parameter int DATA_W       = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] act00,
  input  logic [DATA_W-1:0] act01,
  input  logic [DATA_W-1:0] act10,
  input  logic [DATA_W-1:0] act11,
  input  logic [DATA_W-1:0] w00,
  input  logic [DATA_W-1:0] w01,
  input  logic [DATA_W-1:0] w10,
  input  logic [DATA_W-1:0] w11,
  output logic              busy,
  output logic              done,
  output logic              load_weight,
  output logic              valid,
  output logic [DATA_W-1:0] a_in1,
  output logic [DATA_W-1:0] a_in2,
  output logic [DATA_W-1:0] weight1,
  output logic [DATA_W-1:0] weight2,
  output logic [DATA_W-1:0] weight3,
  output logic [DATA_W-1:0] weight4
`ifdef MMU_FEEDER_DONE_IRQ_EN
  ,
  input  logic              irq_clr,
  output logic              done_irq
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] FEED_LAST  = 4'd2;
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              accept;

  logic [DATA_W-1:0] s_act00, s_act01, s_act10, s_act11;
  logic [DATA_W-1:0] s_w00, s_w01, s_w10, s_w11;

  logic              busy_d, done_d, load_weight_d, valid_d;
  logic [DATA_W-1:0] a_in1_d, a_in2_d;
  logic [DATA_W-1:0] weight1_d, weight2_d, weight3_d, weight4_d;

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (start) state_nx = LOAD_W;
      end
      LOAD_W: begin
        state_nx = FEED;
        cnt_nx   = '0;
      end
      FEED: begin
        if (cnt == FEED_LAST) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Operands are frozen on the accepting edge so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_act00 <= '0;
      s_act01 <= '0;
      s_act10 <= '0;
      s_act11 <= '0;
      s_w00   <= '0;
      s_w01   <= '0;
      s_w10   <= '0;
      s_w11   <= '0;
    end else if (accept) begin
      s_act00 <= act00;
      s_act01 <= act01;
      s_act10 <= act10;
      s_act11 <= act11;
      s_w00   <= w00;
      s_w01   <= w01;
      s_w10   <= w10;
      s_w11   <= w11;
    end
  end

  // Outputs are decoded from the current state and registered, so they trail the state by a cycle.
  always_comb begin
    busy_d        = (state != IDLE);
    done_d        = (state == DONE);
    load_weight_d = (state == LOAD_W);
    valid_d       = (state == FEED) || (state == DRAIN);
    a_in1_d       = '0;
    a_in2_d       = '0;
    weight1_d     = weight1;
    weight2_d     = weight2;
    weight3_d     = weight3;
    weight4_d     = weight4;
    if (state == LOAD_W) begin
      weight1_d = s_w00;
      weight2_d = s_w01;
      weight3_d = s_w10;
      weight4_d = s_w11;
    end
    if (state == FEED) begin
      case (cnt)
        4'd0: a_in1_d = s_act00;
        4'd1: begin
          a_in1_d = s_act10;
          a_in2_d = s_act01;
        end
        4'd2: a_in2_d = s_act11;
        default: begin
          a_in1_d = '0;
          a_in2_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      load_weight <= 1'b0;
      valid       <= 1'b0;
      a_in1       <= '0;
      a_in2       <= '0;
      weight1     <= '0;
      weight2     <= '0;
      weight3     <= '0;
      weight4     <= '0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      load_weight <= load_weight_d;
      valid       <= valid_d;
      a_in1       <= a_in1_d;
      a_in2       <= a_in2_d;
      weight1     <= weight1_d;
      weight2     <= weight2_d;
      weight3     <= weight3_d;
      weight4     <= weight4_d;
    end
  end

`ifdef MMU_FEEDER_DONE_IRQ_EN
  // Set has priority over clear when both land on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_irq <= 1'b0;
    end else if (done) begin
      done_irq <= 1'b1;
    end else if (irq_clr) begin
      done_irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mmu_feeder.sv
// Scoreboard bench for mmu_feeder: a cycle-offset reference model predicts every output each edge.
module tb_mmu_feeder;
  localparam int DW = 16;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [DW-1:0] act00, act01, act10, act11, w00, w01, w10, w11;
  logic          busy, done, load_weight, valid;
  logic [DW-1:0] a_in1, a_in2, weight1, weight2, weight3, weight4;
  logic          irq_clr;
  logic          done_irq;

  always #5 clk = ~clk;

  mmu_feeder #(.DATA_W(DW), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start),
    .act00(act00), .act01(act01), .act10(act10), .act11(act11),
    .w00(w00), .w01(w01), .w10(w10), .w11(w11),
    .busy(busy), .done(done), .load_weight(load_weight), .valid(valid),
    .a_in1(a_in1), .a_in2(a_in2),
    .weight1(weight1), .weight2(weight2), .weight3(weight3), .weight4(weight4)
`ifdef MMU_FEEDER_DONE_IRQ_EN
    , .irq_clr(irq_clr), .done_irq(done_irq)
`endif
  );

  typedef struct {
    logic          busy, done, load_weight, valid, irq;
    logic [DW-1:0] a1, a2, w1, w2, w3, w4;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: m_n is the edge offset since the accepted start (-1 when never started).
  int            m_n = -1;
  logic [DW-1:0] sa00, sa01, sa10, sa11, sw00, sw01, sw10, sw11;
  logic [DW-1:0] mw1, mw2, mw3, mw4;
  logic          m_irq = 1'b0;
  logic          m_done = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    exp_t e;
    if (reset) begin
      m_n = -1;
      {sa00, sa01, sa10, sa11} = '0;
      {sw00, sw01, sw10, sw11} = '0;
      {mw1, mw2, mw3, mw4} = '0;
      m_irq = 1'b0;
    end else begin
`ifdef MMU_FEEDER_DONE_IRQ_EN
      m_irq = m_done ? 1'b1 : (irq_clr ? 1'b0 : m_irq);
`endif
      if (start && (m_n < 0 || m_n >= 5 + DC)) begin
        m_n = 0;
        sa00 = act00; sa01 = act01; sa10 = act10; sa11 = act11;
        sw00 = w00;   sw01 = w01;   sw10 = w10;   sw11 = w11;
      end else if (m_n >= 0) begin
        m_n++;
        if (m_n > 40) m_n = -1;
      end
      if (m_n == 1) begin
        mw1 = sw00; mw2 = sw01; mw3 = sw10; mw4 = sw11;
      end
    end
    e.busy        = (m_n >= 1) && (m_n <= 5 + DC);
    e.load_weight = (m_n == 1);
    e.valid       = (m_n >= 2) && (m_n <= 4 + DC);
    e.done        = (m_n == 5 + DC);
    e.a1          = (m_n == 2) ? sa00 : (m_n == 3) ? sa10 : '0;
    e.a2          = (m_n == 3) ? sa01 : (m_n == 4) ? sa11 : '0;
    e.w1 = mw1; e.w2 = mw2; e.w3 = mw3; e.w4 = mw4;
    e.irq         = m_irq;
    m_done        = e.done;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("busy", 64'(busy), 64'(e.busy));
      check("done", 64'(done), 64'(e.done));
      check("load_weight", 64'(load_weight), 64'(e.load_weight));
      check("valid", 64'(valid), 64'(e.valid));
      check("a_in1", 64'(a_in1), 64'(e.a1));
      check("a_in2", 64'(a_in2), 64'(e.a2));
      check("weight1", 64'(weight1), 64'(e.w1));
      check("weight2", 64'(weight2), 64'(e.w2));
      check("weight3", 64'(weight3), 64'(e.w3));
      check("weight4", 64'(weight4), 64'(e.w4));
`ifdef MMU_FEEDER_DONE_IRQ_EN
      check("done_irq", 64'(done_irq), 64'(e.irq));
`endif
    end
  endtask

  task automatic set_ops(input logic [DW-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
    act00 = a0; act01 = a1; act10 = a2; act11 = a3;
    w00 = b0;   w01 = b1;   w10 = b2;   w11 = b3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; irq_clr = 1'b0;
    set_ops('0, '0, '0, '0, '0, '0, '0, '0);
    step(); step();
    reset = 1'b0;
    repeat (5) step();

    // Basic sequence
    set_ops(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
    start = 1'b1; step(); start = 1'b0;
    repeat (10) step();

    // Operands changed right after the accepting edge must not matter
    set_ops(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
    start = 1'b1; step(); start = 1'b0;
    set_ops('1, '1, '1, '1, '1, '1, '1, '1);
    repeat (10) step();

    // Start while busy and in DONE is dropped; the following edge is accepted
    set_ops(16'h11, 16'h22, 16'h33, 16'h44, 16'h55, 16'h66, 16'h77, 16'h88);
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      start = (k == 3) || (k == 8) || (k == 9);
      if (k == 4) set_ops(16'h9, 16'hA, 16'hB, 16'hC, 16'hD, 16'hE, 16'hF, 16'h10);
      step();
    end
    start = 1'b0;
    repeat (10) step();

    // Reset mid-FEED aborts, then a fresh run completes
    set_ops(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    repeat (3) step();
    set_ops(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606, 16'h0707, 16'h0808);
    start = 1'b1; step(); start = 1'b0;
    repeat (10) step();

`ifdef MMU_FEEDER_DONE_IRQ_EN
    repeat (2) step();
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      irq_clr = (k == 9);
      step();
    end
    irq_clr = 1'b0;
    repeat (3) step();
    irq_clr = 1'b1; step(); irq_clr = 1'b0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
